// File: rtl/uart_io_core.sv
// 8N1 UART engine with a two-register byte interface; UART_RX_FIFO_EN swaps the RX holding register for a FIFO.
// Latency: tx falls 1 cycle after an accepted write; a received byte is visible 1 cycle after its stop sample.
// Backpressure: writes while tx_ready=0 are dropped; received bytes overwrite (or are dropped when FIFO full) and flag overrun.
module uart_io_core #(
   parameter int CLK_DIV       = 434,
   parameter int RX_FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       tx,
   input  logic       io_rd,
   input  logic       io_wr,
   input  logic       io_addr,
   input  logic [7:0] io_din,
   output logic [7:0] io_dout
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic rd_q, wr_q;
   logic data_rd, stat_rd, data_wr;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q <= 1'b0;
         wr_q <= 1'b0;
      end else begin
         rd_q <= io_rd;
         wr_q <= io_wr;
      end
   end

   assign data_rd = io_rd & ~rd_q & ~io_addr;
   assign stat_rd = io_rd & ~rd_q & io_addr;
   assign data_wr = io_wr & ~wr_q & ~io_addr;

   state_t          tx_state, tx_state_nxt;
   logic [CW-1:0]   tx_cnt, tx_cnt_nxt;
   logic [2:0]      tx_bit, tx_bit_nxt;
   logic [7:0]      tx_shift, tx_shift_nxt;
   logic            tx_nxt;
   logic            tx_ready;

   assign tx_ready = (tx_state == S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx       <= 1'b1;
      end else begin
         tx_state <= tx_state_nxt;
         tx_cnt   <= tx_cnt_nxt;
         tx_bit   <= tx_bit_nxt;
         tx_shift <= tx_shift_nxt;
         tx       <= tx_nxt;
      end
   end

   always_comb begin
      tx_state_nxt = tx_state;
      tx_cnt_nxt   = tx_cnt;
      tx_bit_nxt   = tx_bit;
      tx_shift_nxt = tx_shift;
      tx_nxt       = tx;
      case (tx_state)
         S_IDLE: begin
            if (data_wr) begin
               tx_state_nxt = S_START;
               tx_shift_nxt = io_din;
               tx_cnt_nxt   = BIT_LAST;
               tx_nxt       = 1'b0;
            end
         end
         S_START: begin
            if (tx_cnt == '0) begin
               tx_state_nxt = S_DATA;
               tx_cnt_nxt   = BIT_LAST;
               tx_bit_nxt   = 3'd0;
               tx_nxt       = tx_shift[0];
               tx_shift_nxt = {1'b0, tx_shift[7:1]};
            end else begin
               tx_cnt_nxt = tx_cnt - 1'b1;
            end
         end
         S_DATA: begin
            if (tx_cnt == '0) begin
               tx_cnt_nxt = BIT_LAST;
               if (tx_bit == 3'd7) begin
                  tx_state_nxt = S_STOP;
                  tx_nxt       = 1'b1;
               end else begin
                  tx_bit_nxt   = tx_bit + 1'b1;
                  tx_nxt       = tx_shift[0];
                  tx_shift_nxt = {1'b0, tx_shift[7:1]};
               end
            end else begin
               tx_cnt_nxt = tx_cnt - 1'b1;
            end
         end
         default: begin
            if (tx_cnt == '0) begin
               tx_state_nxt = S_IDLE;
            end else begin
               tx_cnt_nxt = tx_cnt - 1'b1;
            end
         end
      endcase
   end

   logic            rx_s1, rx_s2;
   state_t          rx_state, rx_state_nxt;
   logic [CW-1:0]   rx_cnt, rx_cnt_nxt;
   logic [2:0]      rx_bit, rx_bit_nxt;
   logic [7:0]      rx_shift, rx_shift_nxt;
   logic            rx_stop_smp, rx_load, rx_ferr;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_state <= S_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_s1    <= rx;
         rx_s2    <= rx_s1;
         rx_state <= rx_state_nxt;
         rx_cnt   <= rx_cnt_nxt;
         rx_bit   <= rx_bit_nxt;
         rx_shift <= rx_shift_nxt;
      end
   end

   always_comb begin
      rx_state_nxt = rx_state;
      rx_cnt_nxt   = rx_cnt;
      rx_bit_nxt   = rx_bit;
      rx_shift_nxt = rx_shift;
      case (rx_state)
         S_IDLE: begin
            if (!rx_s2) begin
               rx_state_nxt = S_START;
               rx_cnt_nxt   = HALF_LAST;
            end
         end
         S_START: begin
            if (rx_cnt == '0) begin
               // A high level at mid-start means the falling edge was a glitch.
               rx_state_nxt = rx_s2 ? S_IDLE : S_DATA;
               rx_cnt_nxt   = BIT_LAST;
               rx_bit_nxt   = 3'd0;
            end else begin
               rx_cnt_nxt = rx_cnt - 1'b1;
            end
         end
         S_DATA: begin
            if (rx_cnt == '0) begin
               rx_cnt_nxt   = BIT_LAST;
               rx_shift_nxt = {rx_s2, rx_shift[7:1]};
               rx_bit_nxt   = rx_bit + 1'b1;
               if (rx_bit == 3'd7) begin
                  rx_state_nxt = S_STOP;
               end
            end else begin
               rx_cnt_nxt = rx_cnt - 1'b1;
            end
         end
         default: begin
            if (rx_cnt == '0) begin
               rx_state_nxt = S_IDLE;
            end else begin
               rx_cnt_nxt = rx_cnt - 1'b1;
            end
         end
      endcase
   end

   assign rx_stop_smp = (rx_state == S_STOP) && (rx_cnt == '0);
   assign rx_load     = rx_stop_smp & rx_s2;
   assign rx_ferr     = rx_stop_smp & ~rx_s2;

   logic       rx_valid, overrun, frame_err, full_bit;
   logic [7:0] rx_data;

`ifdef UART_RX_FIFO_EN
   localparam int AW = $clog2(RX_FIFO_DEPTH);
   localparam int PW = AW + 1;

   logic [7:0]    fifo_mem [RX_FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          push, pop;

   assign rx_valid = (wr_ptr != rd_ptr);
   assign full_bit = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push     = rx_load & ~full_bit;
   assign pop      = data_rd & rx_valid;
   assign rx_data  = fifo_mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < RX_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= rx_shift;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                        overrun <= 1'b0;
      else if (rx_load && full_bit)   overrun <= 1'b1;
      else if (stat_rd)               overrun <= 1'b0;
   end
`else
   logic [7:0] hold_reg;

   assign full_bit = 1'b0;
   assign rx_data  = hold_reg;

   // A load in the same cycle as a data read keeps rx_valid set.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_valid <= 1'b0;
         hold_reg <= '0;
      end else if (rx_load) begin
         rx_valid <= 1'b1;
         hold_reg <= rx_shift;
      end else if (data_rd) begin
         rx_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                        overrun <= 1'b0;
      else if (rx_load && rx_valid)   overrun <= 1'b1;
      else if (stat_rd)               overrun <= 1'b0;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst)          frame_err <= 1'b0;
      else if (rx_ferr) frame_err <= 1'b1;
      else if (stat_rd) frame_err <= 1'b0;
   end

   always_comb begin
      io_dout = rx_data;
      if (io_addr) io_dout = {3'b000, full_bit, frame_err, overrun, rx_valid, tx_ready};
   end

endmodule

// File: tb/tb_uart_io_core.sv
// Randomized self-checking bench for uart_io_core at CLK_DIV=8, scored against a byte-level model.
module tb_uart_io_core;
   localparam int CLK_DIV    = 8;
   localparam int FIFO_DEPTH = 4;
`ifdef UART_RX_FIFO_EN
   localparam int RX_CAP = FIFO_DEPTH;
`else
   localparam int RX_CAP = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       io_rd = 1'b0;
   logic       io_wr = 1'b0;
   logic       io_addr = 1'b0;
   logic [7:0] io_din = 8'h00;
   logic       tx;
   logic [7:0] io_dout;

   int n_checks = 0;
   int n_fail   = 0;

   // Receive model: queue of pending bytes, capacity 1 (overwrite) or the FIFO depth (drop).
   logic [7:0] m_q[$];
   bit         m_ovr, m_ferr;

   uart_io_core #(.CLK_DIV(CLK_DIV), .RX_FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .rx(rx), .tx(tx),
      .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
      .io_din(io_din), .io_dout(io_dout)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_status(input bit txr);
      bit full;
`ifdef UART_RX_FIFO_EN
      full = (m_q.size() == FIFO_DEPTH);
`else
      full = 1'b0;
`endif
      return {3'b000, full, m_ferr, m_ovr, (m_q.size() != 0), txr};
   endfunction

   function automatic void model_rx(input logic [7:0] b, input logic stop);
      if (!stop) begin
         m_ferr = 1'b1;
      end else if (m_q.size() < RX_CAP) begin
         m_q.push_back(b);
      end else begin
         m_ovr = 1'b1;
         if (RX_CAP == 1) m_q[0] = b;
      end
   endfunction

   function automatic void model_reset();
      m_q.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
   endfunction

   task automatic do_read(input logic a, input int hold, output logic [7:0] val);
      @(negedge clk);
      io_addr = a;
      io_rd   = 1'b1;
      #1 val = io_dout;
      repeat (hold) @(negedge clk);
      io_rd = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      logic bitv;
      for (int i = 0; i < 10; i++) begin
         bitv = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
         @(negedge clk);
         rx = bitv;
         repeat (CLK_DIV - 1) @(negedge clk);
      end
      @(negedge clk);
      rx = 1'b1;
      repeat (12) @(negedge clk);
      model_rx(b, stop);
   endtask

   task automatic read_status(input string name);
      logic [7:0] v, e;
      e = exp_status(1'b1);
      do_read(1'b1, $urandom_range(1, 3), v);
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      n_checks++;
      if (v !== e) begin
         n_fail++;
         $display("FAIL %s status: got %h expected %h", name, v, e);
      end
   endtask

   task automatic read_data(input string name);
      logic [7:0] v, e;
      e = m_q.pop_front();
      do_read(1'b0, $urandom_range(1, 3), v);
      n_checks++;
      if (v !== e) begin
         n_fail++;
         $display("FAIL %s data: got %h expected %h", name, v, e);
      end
   endtask

   task automatic drain(input string name);
      while (m_q.size() != 0) read_data(name);
      read_status(name);
   endtask

   task automatic tx_frame_check(input logic [7:0] b, input bit extra_write, input string name);
      logic exp_tx;
      int   k;
      @(negedge clk);
      io_addr = 1'b0;
      io_din  = b;
      io_wr   = 1'b1;
      for (int i = 1; i <= 90; i++) begin
         @(negedge clk);
         if (i == 3) begin io_wr = 1'b0; io_addr = 1'b1; end
         if (extra_write && i == 20) begin io_addr = 1'b0; io_din = 8'h3C; io_wr = 1'b1; end
         if (extra_write && i == 23) begin io_wr = 1'b0; io_addr = 1'b1; end
         #1;
         k = (i - 1) / CLK_DIV;
         if (i > 10 * CLK_DIV) exp_tx = 1'b1;
         else if (k == 0)      exp_tx = 1'b0;
         else if (k <= 8)      exp_tx = b[k-1];
         else                  exp_tx = 1'b1;
         n_checks++;
         if (tx !== exp_tx) begin
            n_fail++;
            $display("FAIL %s tx cycle %0d: got %b expected %b", name, i, tx, exp_tx);
         end
         if (i >= 3 && !(extra_write && i >= 20 && i < 23)) begin
            n_checks++;
            if (io_dout[0] !== (i > 10 * CLK_DIV)) begin
               n_fail++;
               $display("FAIL %s tx_ready cycle %0d: got %b expected %b", name, i, io_dout[0], (i > 10 * CLK_DIV));
            end
         end
      end
   endtask

   task automatic test_reset();
      repeat (4) @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL reset tx: got %b expected 1", tx); end
      n_checks++;
      if (io_dout !== 8'h00) begin n_fail++; $display("FAIL reset hold: got %h expected 00", io_dout); end
      repeat (50) @(negedge clk);
      n_checks++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL idle tx: got %b expected 1", tx); end
      read_status("reset");
   endtask

   task automatic test_tx();
      tx_frame_check(8'hA5, 1'b1, "tx_a5");
      for (int n = 0; n < 2; n++) tx_frame_check(8'($urandom), 1'b0, "tx_rand");
   endtask

   task automatic test_rx_basic();
      send_rx(8'h5A, 1'b1);
      read_status("rx_5a");
      read_data("rx_5a");
      read_status("rx_5a_after");
   endtask

   task automatic test_overrun();
      send_rx(8'h11, 1'b1);
      send_rx(8'h22, 1'b1);
      read_status("ovr_first");
      read_status("ovr_cleared");
      drain("ovr_drain");
   endtask

   task automatic test_frame_err();
      send_rx(8'h77, 1'b1);
      send_rx(8'hFF, 1'b0);
      read_status("ferr_set");
      read_status("ferr_clr");
      drain("ferr_drain");
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         send_rx(8'($urandom), ($urandom_range(0, 3) != 0));
         case ($urandom_range(0, 2))
            0: ;
            1: read_status("rand_stat");
            default: if (m_q.size() != 0) read_data("rand_data");
         endcase
      end
      drain("rand_drain");
   endtask

   task automatic test_full_duplex();
      logic [7:0] tb_b, rb_b;
      tb_b = 8'($urandom);
      rb_b = 8'($urandom);
      fork
         tx_frame_check(tb_b, 1'b0, "duplex_tx");
         begin
            repeat (5) @(negedge clk);
            send_rx(rb_b, 1'b1);
         end
      join
      drain("duplex_rx");
   endtask

   task automatic test_reset_mid_tx();
      @(negedge clk);
      io_addr = 1'b0;
      io_din  = 8'($urandom);
      io_wr   = 1'b1;
      @(negedge clk);
      io_wr = 1'b0;
      repeat ($urandom_range(10, 60)) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      io_addr = 1'b1;
      #1;
      n_checks++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid tx: got %b expected 1", tx); end
      n_checks++;
      if (io_dout[0] !== 1'b1) begin n_fail++; $display("FAIL rst_mid tx_ready: got %b expected 1", io_dout[0]); end
      rst = 1'b0;
      model_reset();
      read_status("rst_mid_status");
   endtask

`ifdef UART_RX_FIFO_EN
   task automatic test_fifo();
      logic [7:0] v;
      for (int n = 1; n <= 5; n++) send_rx(8'(n), 1'b1);
      @(negedge clk);
      io_addr = 1'b1;
      #1 v = io_dout;
      n_checks++;
      if (v[4] !== 1'b1) begin n_fail++; $display("FAIL fifo_full bit: got %b expected 1", v[4]); end
      read_status("fifo_status");
      drain("fifo_drain");
   endtask
`endif

   initial begin
      test_reset();
      test_tx();
      test_rx_basic();
      test_overrun();
      test_frame_err();
      test_random();
      test_full_duplex();
      test_reset_mid_tx();
`ifdef UART_RX_FIFO_EN
      test_fifo();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_io_core.md
Name: uart_io_core

Overview:
- 8N1 UART engine that sits directly below the Wishbone UART adapter on the J1 I/O bus.
- Exposes a two-register byte interface (io_rd/io_wr/io_addr/io_din/io_dout) to that adapter.
- Drives the serial tx pin and receives on the rx pin.
- Contains baud timing, TX shifter, RX sampler with synchronizer, a receive holding register and status flags.

Parameters:
- CLK_DIV, 434, clock cycles per serial bit (50 MHz / 115200); legal range 4..65535.
- RX_FIFO_DEPTH, 4, receive FIFO entries; used only when UART_RX_FIFO_EN is defined; power of 2, range 2..16.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial input, idle high
- tx  output  1  serial output, idle high
- io_rd  input  1  read strobe; level, may be held for several cycles
- io_wr  input  1  write strobe; level, may be held for several cycles
- io_addr  input  1  register select: 0 = data, 1 = status
- io_din  input  8  write data
- io_dout  output  8  read data, combinational from io_addr and current state

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - tx=1; TX idle; RX idle.
  - Synchronizer flops = 1.
  - rx_valid=0, overrun=0, frame_err=0; holding register = 0.
- Register map:
  - io_dout when io_addr=0: RX holding byte.
  - io_dout when io_addr=1: {4'b0, frame_err, overrun, rx_valid, tx_ready}.
- Strobe qualification:
  - A side effect fires only on the first cycle of an io_rd or io_wr assertion (rising edge vs. registered copy; registered copy resets to 0).
  - Holding a strobe high repeats nothing.
- Write, addr 0:
  - If tx_ready=1, latch io_din and start a frame; tx_ready drops to 0 the next cycle.
  - If tx_ready=0, drop the write silently.
- Write, addr 1: ignored.
- Read, addr 0: clears rx_valid on the following cycle. io_dout is still valid in the cycle of the read.
- Read, addr 1: clears overrun and frame_err on the following cycle.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - tx goes low the cycle after the accepting write.
  - Each bit lasts exactly CLK_DIV cycles; data is sent LSB first.
  - Stop bit is 1; tx_ready returns to 1 the cycle after the stop bit ends.
  - Frame length = 10*CLK_DIV cycles.
- RX input: 2-flop synchronizer on rx. All RX logic uses the synchronized signal.
- RX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE→START on synchronized rx = 0.
  - START samples at CLK_DIV/2 (integer division). If the sample is 1, treat it as a glitch and return to IDLE.
  - DATA samples 8 bits, each CLK_DIV cycles after the previous sample, shifting in LSB first.
  - STOP samples once more after CLK_DIV cycles.
- Stop bit = 1:
  - Load the holding register and set rx_valid.
  - If rx_valid was already 1, set overrun and overwrite the holding byte with the new byte.
- Stop bit = 0: set frame_err, discard the byte, leave rx_valid unchanged.
- RX returns to IDLE right after the stop sample; it does not wait for the line to go high. A line held low retriggers START.
- Simultaneous events:
  - Data read and new-byte load in the same cycle: the load wins (rx_valid stays 1).
  - Status read and an error set in the same cycle: the set wins.
- Full duplex: TX and RX run independently.
- Reset mid-frame: both FSMs abort to IDLE; tx=1 on the next cycle.
- Counters are sized with $clog2(CLK_DIV) and wrap only through explicit reload. No free-running overflow.

Optional Feature:
- Macro: UART_RX_FIFO_EN.
- When defined:
  - Received bytes go into an RX_FIFO_DEPTH-entry FIFO, with bit counter and pointers of width $clog2(RX_FIFO_DEPTH)+1.
  - rx_valid means FIFO not empty; addr 0 shows the head entry.
  - A data read pops one entry.
  - A byte arriving when the FIFO is full is dropped and sets overrun; FIFO contents are kept.
  - Pop and push in the same cycle are both performed.
  - Status bit 4 = FIFO full.
- When undefined: single holding register as above; status bit 4 = 0.

Test Plan:
- All tests use CLK_DIV=8.
- Reset, then idle 50 cycles -> tx=1; status at addr 1 reads 8'h01.
- Write addr 0 with 8'hA5 and hold io_wr for 3 cycles -> exactly one frame:
  - tx low for 8 cycles, then bits 1,0,1,0,0,1,0,1 at 8 cycles each, then stop high.
  - tx_ready=0 for 80 cycles.
- Second write of 8'h3C during that frame -> ignored; only 8'hA5 appears on tx.
- Drive rx with frame 8'h5A -> status reads 8'h03 and addr 0 reads 8'h5A. A following addr 0 read makes status return 8'h01.
- Drive 8'h11 then 8'h22 with no read -> status 8'h07 and data 8'h22. Status read clears overrun, so status reads 8'h03.
- Drive frame 8'hFF with stop bit 0 -> frame_err=1 and rx_valid unchanged.
- Assert rst mid-TX-frame -> tx=1 next cycle and tx_ready=1.
- With UART_RX_FIFO_EN and depth 4, drive 5 bytes 01..05 -> reads return 01..04, overrun=1, and bit 4 set before the first pop.
